// File: rtl/maxpool_spike_feeder.sv
// Streams in_ch x img_size spike rows from the spike buffer into maxpool.
// Define MAXPOOL_FEEDER_STALL_CNT_EN to build the back-pressure stall counter.
module maxpool_spike_feeder #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              code_valid,
  input  logic [15:0]       conv_in_ch,
  input  logic [15:0]       conv_img_size,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              o_spikes_valid,
  output logic [DATA_W-1:0] o_spikes,
  input  logic              i_spikes_ready,
  input  logic              i_pool_done,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE
  } state_t;

  state_t state;

  logic [31:0]       total;
  logic [31:0]       issue_cnt;
  logic [31:0]       accept_cnt;
  logic [ADDR_W-1:0] base;
  logic              rd_vld;

  logic [DATA_W-1:0] fifo_q [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        occ;

  logic [31:0]       req_total;
  logic [3:0]        fill;
  logic              push;
  logic              pop;
  logic              issue;
  logic              start;

  assign req_total = 32'(conv_in_ch) * 32'(conv_img_size);
  assign start     = (state == IDLE) && code_valid && (req_total != 32'd0);

  assign o_spikes_valid = (occ != 3'd0);
  assign o_spikes       = o_spikes_valid ? fifo_q[rd_ptr] : '0;

  assign push = rd_vld;
  assign pop  = o_spikes_valid && i_spikes_ready;

  // Rows buffered plus reads outstanding after this edge stay <= 3.
  assign fill  = {1'b0, occ} + {3'b0, rd_vld} + {3'b0, mem_rd_en};
  assign issue = (state == STREAM)
              && (issue_cnt < total)
              && (fill <= (4'd2 + {3'b0, pop}));

  always_ff @(posedge s_clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= mem_rd_data;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= IDLE;
      total       <= '0;
      issue_cnt   <= '0;
      accept_cnt  <= '0;
      base        <= '0;
      rd_vld      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      rd_vld <= mem_rd_en;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      occ <= occ + {2'b0, push} - {2'b0, pop};

      unique case (state)
        IDLE: begin
          mem_rd_en <= 1'b0;
          o_busy    <= 1'b0;
          if (code_valid) begin
            if (req_total == 32'd0) begin
              o_done <= 1'b1;
            end else begin
              state       <= STREAM;
              total       <= req_total;
              base        <= base_addr;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr;
              issue_cnt   <= 32'd1;
              accept_cnt  <= '0;
              o_busy      <= 1'b1;
            end
          end
        end
        STREAM: begin
          mem_rd_en <= issue;
          if (issue) begin
            mem_rd_addr <= base + issue_cnt[ADDR_W-1:0];
            issue_cnt   <= issue_cnt + 32'd1;
          end
          if (pop) begin
            accept_cnt <= accept_cnt + 32'd1;
            if (accept_cnt + 32'd1 == total) begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          mem_rd_en <= 1'b0;
          if (i_pool_done) begin
            o_done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAXPOOL_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      stall_q <= '0;
    end else if (start) begin
      stall_q <= '0;
    end else if ((state == STREAM) && o_spikes_valid
              && !i_spikes_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`else
  logic unused_start;
  assign unused_start = start;
  assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_maxpool_spike_feeder.sv
// Scoreboard bench for maxpool_spike_feeder: reference address/row lists
// are built per code word and popped by a negedge monitor.
module tb_maxpool_spike_feeder;
  localparam int DW = 128;
  localparam int AW = 16;

  logic          s_clk = 1'b0;
  logic          s_rst_n = 1'b1;
  logic          code_valid = 1'b0;
  logic [15:0]   conv_in_ch = '0;
  logic [15:0]   conv_img_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          o_spikes_valid;
  logic [DW-1:0] o_spikes;
  logic          i_spikes_ready = 1'b0;
  logic          i_pool_done = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic [31:0]   o_stall_cnt;

  maxpool_spike_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .s_clk         (s_clk),
    .s_rst_n       (s_rst_n),
    .code_valid    (code_valid),
    .conv_in_ch    (conv_in_ch),
    .conv_img_size (conv_img_size),
    .base_addr     (base_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .o_spikes_valid(o_spikes_valid),
    .o_spikes      (o_spikes),
    .i_spikes_ready(i_spikes_ready),
    .i_pool_done   (i_pool_done),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_stall_cnt   (o_stall_cnt)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {logic [AW-1:0] a; int at;} rd_t;
  typedef struct {logic [DW-1:0] d; int at;} row_t;

  rd_t  rd_q[$];
  row_t row_q[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int t0 = 0;
  int rmode = 0;
  bit plain = 1'b1;
  logic [15:0] salt = '0;
  int issued = 0;
  int accepted = 0;
  int stalls = 0;
  bit done_ok = 1'b0;
  bit stalled_prev = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ram_row(input logic [AW-1:0] a);
    if (plain) return DW'(a);
    return {{7{a ^ salt}}, a};
  endfunction

  always @(posedge s_clk) cyc++;

  always @(posedge s_clk) begin
    if (mem_rd_en) mem_rd_data <= ram_row(mem_rd_addr);
  end

  initial begin
    forever begin
      @(posedge s_clk);
      #2;
      case (rmode)
        0: i_spikes_ready = 1'b1;
        1: i_spikes_ready = ((cyc - t0) % 3 == 0);
        default: i_spikes_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every read strobe and row handshake.
  always @(negedge s_clk) begin
    rd_t  r;
    row_t w;
    int   rel;
    rel = cyc - t0;
    if (!s_rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        issued++;
        if (rd_q.size() == 0) begin
          chk("spurious_rd", 1, 0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_addr", mem_rd_addr, r.a);
          if (r.at >= 0) chk("rd_cycle", rel, r.at);
        end
      end
      if (stalled_prev) begin
        chk("stall_hold_valid", o_spikes_valid, 1);
        chk("stall_hold_data", o_spikes, held);
      end
      if (o_spikes_valid && i_spikes_ready) begin
        accepted++;
        if (row_q.size() == 0) begin
          chk("spurious_row", 1, 0);
        end else begin
          w = row_q.pop_front();
          chk("row_data", o_spikes, w.d);
          if (w.at >= 0) chk("row_cycle", rel, w.at);
        end
      end
      if (mem_rd_en || o_spikes_valid)
        chk("buffered_le3", (issued - accepted) <= 3, 1);
      stalled_prev = o_spikes_valid && !i_spikes_ready;
      if (stalled_prev) stalls++;
      held = o_spikes;
      if (o_done && !done_ok) chk("spurious_done", 1, 0);
    end
  end

  task automatic run(input int in_ch, input int img, input int base,
                     input int mode, input bit pl, input bit timing,
                     input int pd_at, input int extra_at,
                     input int rst_at, input bit noise);
    int  total;
    int  rel;
    bit  fin;
    bit  aborted;
    logic [AW-1:0] a;
    total = in_ch * img;
    fin = 1'b0;
    aborted = 1'b0;
    plain = pl;
    salt = 16'($urandom);
    rd_q.delete();
    row_q.delete();
    for (int k = 0; k < total; k++) begin
      a = AW'(base + k);
      rd_q.push_back('{a: a, at: timing ? 1 + k : -1});
      row_q.push_back('{d: ram_row(a), at: timing ? 3 + k : -1});
    end
    @(posedge s_clk);
    #1;
    rmode = mode;
    conv_in_ch = 16'(in_ch);
    conv_img_size = 16'(img);
    base_addr = AW'(base);
    code_valid = 1'b1;
    t0 = cyc;
    issued = 0;
    accepted = 0;
    if (total != 0) stalls = 0;
    done_ok = (total == 0);
    @(negedge s_clk);
    #1;
    chk("busy_c0", o_busy, 0);
    chk("done_c0", o_done, 0);
    if (total == 0) begin
      @(posedge s_clk);
      #1;
      code_valid = 1'b0;
      @(negedge s_clk);
      #1;
      chk("zero_done", o_done, 1);
      chk("zero_busy", o_busy, 0);
      done_ok = 1'b0;
      repeat (3) begin
        @(negedge s_clk);
        #1;
        chk("zero_busy_after", o_busy, 0);
      end
      return;
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge s_clk);
      #1;
      rel = cyc - t0;
      if (noise) i_pool_done = 1'($urandom_range(0, 1));
      if (rel == extra_at) begin
        code_valid = 1'b1;
        conv_in_ch = 16'd9;
      end else begin
        code_valid = 1'b0;
      end
      if (rel == rst_at) begin
        #2;
        s_rst_n = 1'b0;
        #1;
        rd_q.delete();
        row_q.delete();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_valid", o_spikes_valid, 0);
        chk("rst_spikes", o_spikes, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_stall", o_stall_cnt, 0);
        repeat (2) @(negedge s_clk);
        s_rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge s_clk);
      #1;
      if (rel == 1) chk("busy_c1", o_busy, 1);
      if (row_q.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    i_pool_done = 1'b0;
    code_valid = 1'b0;
    if (aborted) begin
      repeat (4) begin
        @(negedge s_clk);
        #1;
        chk("abort_busy", o_busy, 0);
      end
      return;
    end
    if (!fin) begin
      chk("stream_timeout", 0, 1);
      return;
    end
    do begin
      @(posedge s_clk);
      #1;
    end while (cyc - t0 < pd_at);
    chk("busy_wait", o_busy, 1);
    i_pool_done = 1'b1;
    done_ok = 1'b1;
    rel = cyc - t0;
    @(negedge s_clk);
    #1;
    chk("done_early", o_done, 0);
    @(posedge s_clk);
    #1;
    i_pool_done = 1'b0;
    @(negedge s_clk);
    #1;
    chk("done_pulse", o_done, 1);
    chk("busy_at_done", o_busy, 1);
    chk("done_cycle", cyc - t0, rel + 1);
    @(negedge s_clk);
    #1;
    done_ok = 1'b0;
    chk("done_drop", o_done, 0);
    chk("busy_drop", o_busy, 0);
`ifdef MAXPOOL_FEEDER_STALL_CNT_EN
    chk("stall_cnt", o_stall_cnt, stalls);
`else
    chk("stall_cnt", o_stall_cnt, 0);
`endif
  endtask

  initial begin
    int ic;
    int im;
    int bs;
    #1;
    s_rst_n = 1'b0;
    #1;
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_rd_addr", mem_rd_addr, 0);
    chk("reset_valid", o_spikes_valid, 0);
    chk("reset_spikes", o_spikes, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_stall", o_stall_cnt, 0);
    repeat (3) @(posedge s_clk);
    #1;
    s_rst_n = 1'b1;
    repeat (2) @(posedge s_clk);

    run(2, 4, 'h0100, 0, 1, 1, 15, -1, -1, 0);
    run(2, 4, 'h0100, 1, 1, 0, 0, -1, -1, 0);
    run(0, 7, 'h0200, 0, 1, 1, 0, -1, -1, 0);
    run(1, 4, 'hFFFE, 0, 1, 1, 0, -1, -1, 0);
    run(2, 4, 'h0300, 0, 0, 1, 0, 5, -1, 0);
    run(2, 4, 'h0400, 0, 0, 1, 0, -1, 6, 0);
    run(2, 3, 'h0500, 0, 0, 1, 0, -1, -1, 0);
    for (int i = 0; i < 16; i++) begin
      ic = int'($urandom_range(0, 3));
      im = int'($urandom_range(0, 6));
      bs = (i % 4 == 0) ? int'($urandom_range(16'hFFF8, 16'hFFFF))
                        : int'($urandom_range(0, 16'hFFFF));
      run(ic, im, bs, 2, 0, 0, int'($urandom_range(0, 40)),
          -1, -1, 1);
      repeat (int'($urandom_range(0, 3))) @(posedge s_clk);
    end
    run(3, 5, 'h1234, 1, 0, 0, 0, -1, -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
